// File: rtl/ram_pkg.sv
// Shared definitions for the RAM sequencing controller: default geometry,
// controller state encoding and the fill test pattern.
package ram_pkg;

    localparam int AW_DEF    = 10;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 1 << AW_DEF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_SETUP = 3'd1,
        W_PULSE = 3'd2,
        W_HOLD  = 3'd3,
        R_SETUP = 3'd4,
        R_CAPT  = 3'd5,
        R_RESP  = 3'd6
    } state_t;

    // Fill pattern: twice the address; callers truncate to their data width,
    // which gives the mod 2^DW wrap.
    function automatic logic [31:0] fill_pattern(input logic [31:0] addr);
        return addr << 1;
    endfunction

endpackage

// File: rtl/ram_fill_gen.sv
// Fill engine counters: tracks the address currently being written and the
// words still to go, and offers the following address/data to the FSM.
module ram_fill_gen
    import ram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [AW-1:0] i_base,
    input  logic [AW:0]   i_count,
    output logic [DW-1:0] o_base_data,
    output logic [AW-1:0] o_next_addr,
    output logic [DW-1:0] o_next_data,
    output logic          o_last
);

    logic [AW-1:0] r_addr;
    logic [AW:0]   r_remain;
    logic [AW-1:0] w_next_addr;

    // Address increment wraps naturally at 2^AW.
    assign w_next_addr = r_addr + 1'b1;

    assign o_base_data = DW'(fill_pattern(32'(i_base)));
    assign o_next_addr = w_next_addr;
    assign o_next_data = DW'(fill_pattern(32'(w_next_addr)));
    // Remaining count includes the word in flight, so 1 means it is the last.
    assign o_last      = (r_remain == {{AW{1'b0}}, 1'b1});

    // Load on fill start, advance once per completed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_addr   <= i_base;
            r_remain <= i_count;
        end else if (i_step) begin
            r_addr   <= w_next_addr;
            r_remain <= r_remain - 1'b1;
        end
    end

endmodule

// File: rtl/ram_seq_ctrl.sv
// Clocked front-end for a single-port RAM with combinational read: turns
// valid/ready requests into setup/pulse/hold writes and registered reads,
// and runs a self-timed pattern fill over an address range.
module ram_seq_ctrl
    import ram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW:0]   fill_count,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_wr,
    output logic          mem_cs,
    input  logic [DW-1:0] mem_dout
);

    state_t        r_state;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic          r_fill_busy;
    logic          r_fill_done;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;
    logic          r_mem_wr;
    logic          r_mem_cs;

    logic          w_accept;
    logic          w_fill_go;
    logic          w_fill_load;
    logic          w_fill_step;
    logic          w_fill_last;
    logic [DW-1:0] w_base_data;
    logic [AW-1:0] w_next_addr;
    logic [DW-1:0] w_next_data;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign fill_busy = r_fill_busy;
    assign fill_done = r_fill_done;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_wr    = r_mem_wr;
    assign mem_cs    = r_mem_cs;

    // A fill start in IDLE takes priority; the competing request stays
    // pending because it is not accepted this cycle.
    assign w_fill_go   = fill_start && (r_state == IDLE) && !r_fill_busy;
    assign w_fill_load = w_fill_go && (fill_count != '0);
    assign w_accept    = req_valid && r_req_ready && !w_fill_go;
    assign w_fill_step = (r_state == W_HOLD) && r_fill_busy && !w_fill_last;

    ram_fill_gen #(
        .AW (AW),
        .DW (DW)
    ) u_fill_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_fill_load),
        .i_step      (w_fill_step),
        .i_base      (fill_base),
        .i_count     (fill_count),
        .o_base_data (w_base_data),
        .o_next_addr (w_next_addr),
        .o_next_data (w_next_data),
        .o_last      (w_fill_last)
    );

    // Main sequencer: every RAM strobe and handshake output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_cs    <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_mem_wr <= 1'b0;
                    r_mem_cs <= 1'b0;
                    if (w_fill_go) begin
                        if (fill_count == '0) begin
                            // Empty fill: report completion without touching RAM.
                            r_fill_done <= 1'b1;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_fill_busy <= 1'b1;
                            r_req_ready <= 1'b0;
                            r_mem_addr  <= fill_base;
                            r_mem_din   <= w_base_data;
                            r_mem_cs    <= 1'b1;
                            r_state     <= W_SETUP;
                        end
                    end else if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_mem_addr  <= req_addr;
                        r_mem_cs    <= 1'b1;
                        if (req_we) begin
                            r_mem_din <= req_wdata;
                            r_state   <= W_SETUP;
                        end else begin
                            r_state   <= R_SETUP;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                W_SETUP: begin
                    r_mem_wr <= 1'b1;
                    r_state  <= W_PULSE;
                end
                W_PULSE: begin
                    // Address and data stay put through the hold cycle.
                    r_mem_wr <= 1'b0;
                    r_mem_cs <= 1'b0;
                    r_state  <= W_HOLD;
                end
                W_HOLD: begin
                    if (r_fill_busy && !w_fill_last) begin
                        r_mem_addr <= w_next_addr;
                        r_mem_din  <= w_next_data;
                        r_mem_cs   <= 1'b1;
                        r_state    <= W_SETUP;
                    end else begin
                        if (r_fill_busy) begin
                            r_fill_busy <= 1'b0;
                            r_fill_done <= 1'b1;
                        end
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                R_SETUP: begin
                    // RAM read path is combinational from mem_addr.
                    r_rsp_data  <= mem_dout;
                    r_rsp_valid <= 1'b1;
                    r_mem_cs    <= 1'b0;
                    r_state     <= R_CAPT;
                end
                R_CAPT, R_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_state     <= R_RESP;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
